// File: rtl/move_debouncer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// move_debouncer_pkg : shared game timing constants and strobe FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package move_debouncer_pkg;

  localparam int CLK_HZ = 36_000_000;

  // 10 ms debounce, 250 ms first-repeat delay, 100 ms repeat period
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEF_REPEAT_DELAY    = CLK_HZ / 4;
  localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } strobe_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_debouncer_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_channel : 2-flop synchronizer plus stable-count debounce of one button
// Rev 1.0
// ---------------------------------------------------------------------------
module debounce_channel
  import move_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk_36MHz,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk_36MHz) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // any return to the accepted level restarts the stability count
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/move_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// move_debouncer : debounced, mutually exclusive, auto-repeating move strobes
// Rev 1.0
// ---------------------------------------------------------------------------
module move_debouncer
  import move_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk_36MHz,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_left_raw,
  input  logic i_right_raw,
  output logic o_left_debounced,
  output logic o_right_debounced,
  output logic o_left_level,
  output logic o_right_level
);

  localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TW-1:0] c_delay_last  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] c_period_last = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] c_timer_one   = TW'(1);

  // index 0 = left, 1 = right
  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_go;
  logic [1:0] w_strobe;

  assign w_raw = {i_right_raw, i_left_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      strobe_state_t r_state;
      logic [TW-1:0] r_timer;
      logic          r_strobe;

      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_clk_36MHz(i_clk_36MHz),
        .i_reset    (i_reset),
        .i_raw      (w_raw[gi]),
        .o_level    (w_level[gi])
      );

      // the opposite level vetoes go, so both strobes can never fire together
      assign w_go[gi] = w_level[gi] & ~w_level[1-gi] & i_enable;

      always_ff @(posedge i_clk_36MHz) begin
        if (!i_reset) begin
          r_state  <= ST_IDLE;
          r_timer  <= '0;
          r_strobe <= 1'b0;
        end else begin
          r_strobe <= 1'b0;
          if (!w_go[gi]) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else begin
            case (r_state)
              ST_IDLE: begin
                r_strobe <= 1'b1;
                r_timer  <= '0;
                r_state  <= ST_DELAY;
              end
              ST_DELAY: begin
                if (r_timer == c_delay_last) begin
                  r_strobe <= 1'b1;
                  r_timer  <= '0;
                  r_state  <= ST_REPEAT;
                end else begin
                  r_timer <= r_timer + c_timer_one;
                end
              end
              ST_REPEAT: begin
                if (r_timer == c_period_last) begin
                  r_strobe <= 1'b1;
                  r_timer  <= '0;
                end else begin
                  r_timer <= r_timer + c_timer_one;
                end
              end
              default: begin
                r_state <= ST_IDLE;
                r_timer <= '0;
              end
            endcase
          end
        end
      end

      assign w_strobe[gi] = r_strobe;
    end
  endgenerate

  assign o_left_debounced  = w_strobe[0];
  assign o_right_debounced = w_strobe[1];
  assign o_left_level      = w_level[0];
  assign o_right_level     = w_level[1];

endmodule
`default_nettype wire

// File: tb/tb_move_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_move_debouncer : directed self-checking bench, short debounce/repeat timing
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_move_debouncer;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b1;
  logic l_raw   = 1'b1;
  logic r_raw   = 1'b1;
  logic l_stb;
  logic r_stb;
  logic l_lvl;
  logic r_lvl;

  int n_checks = 0;
  int n_errors = 0;

  move_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .i_clk_36MHz      (clk),
    .i_reset          (rst_n),
    .i_enable         (en),
    .i_left_raw       (l_raw),
    .i_right_raw      (r_raw),
    .o_left_debounced (l_stb),
    .o_right_debounced(r_stb),
    .o_left_level     (l_lvl),
    .o_right_level    (r_lvl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs set before a call are sampled at its edge; outputs read 1 ns after
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    l_raw = 1'b0;
    r_raw = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // left high for 8 sampled edges: level at t=5..12, single strobe at t=6
  task automatic press_left8(input string name);
    for (int t = 0; t < 20; t++) begin
      l_raw = (t < 8);
      tick();
      check($sformatf("%s l_lvl t=%0d", name, t), int'(l_lvl), int'(t >= 5 && t <= 12));
      check($sformatf("%s l_stb t=%0d", name, t), int'(l_stb), int'(t == 6));
      check($sformatf("%s r_stb t=%0d", name, t), int'(r_stb), 0);
    end
  endtask

  initial begin
    int pat[7];
    int nstb;
    bit exp_s;

    // reset held with both buttons pressed
    for (int i = 0; i < 3; i++) tick();
    check("rst l_stb", int'(l_stb), 0);
    check("rst r_stb", int'(r_stb), 0);
    check("rst l_lvl", int'(l_lvl), 0);
    check("rst r_lvl", int'(r_lvl), 0);
    rst_n = 1'b1;
    r_raw = 1'b0;
    press_left8("post_rst");
    settle(5);

    press_left8("single");
    settle(5);

    // bounce: no run of highs reaches the debounce length
    pat = '{1, 0, 1, 1, 1, 0, 1};
    for (int t = 0; t < 16; t++) begin
      l_raw = (t < 7) ? pat[t][0] : 1'b0;
      tick();
      check($sformatf("bounce l_lvl t=%0d", t), int'(l_lvl), 0);
      check($sformatf("bounce l_stb t=%0d", t), int'(l_stb), 0);
    end
    press_left8("after_bounce");
    settle(5);

    // auto-repeat, right held 42 edges; release falls clear of a repeat slot
    nstb = 0;
    for (int t = 0; t < 60; t++) begin
      r_raw = (t < 42);
      tick();
      exp_s = (t == 6) || (t >= 16 && t <= 46 && (t - 16) % RP == 0);
      check($sformatf("rep r_lvl t=%0d", t), int'(r_lvl), int'(t >= 5 && t <= 46));
      check($sformatf("rep r_stb t=%0d", t), int'(r_stb), int'(exp_s));
      check($sformatf("rep l_stb t=%0d", t), int'(l_stb), 0);
      if (r_stb) nstb++;
    end
    check("rep count", nstb, 12);
    settle(5);

    // left held, right pressed t=21..39, left released at t=58
    for (int t = 0; t < 70; t++) begin
      l_raw = (t < 58);
      r_raw = (t >= 21 && t < 40);
      tick();
      exp_s = (t == 6) || (t >= 16 && t <= 25 && (t - 16) % RP == 0) || (t == 46) ||
              (t >= 56 && t <= 62 && (t - 56) % RP == 0);
      check($sformatf("both l_lvl t=%0d", t), int'(l_lvl), int'(t >= 5 && t <= 62));
      check($sformatf("both r_lvl t=%0d", t), int'(r_lvl), int'(t >= 26 && t <= 44));
      check($sformatf("both l_stb t=%0d", t), int'(l_stb), int'(exp_s));
      check($sformatf("both r_stb t=%0d", t), int'(r_stb), 0);
    end
    settle(5);

    // enable low while held, raised at t=12, dropped again at t=25 (a repeat slot)
    for (int t = 0; t < 40; t++) begin
      r_raw = (t < 30);
      en    = (t >= 12 && t < 25);
      tick();
      check($sformatf("en r_lvl t=%0d", t), int'(r_lvl), int'(t >= 5 && t <= 34));
      check($sformatf("en r_stb t=%0d", t), int'(r_stb), int'(t == 12 || t == 22));
      check($sformatf("en l_stb t=%0d", t), int'(l_stb), 0);
    end
    en = 1'b1;
    settle(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
